demux_1to2: RTL and testbench

- Registered 1-to-2 demultiplexer. Routes one input data word to output channel 0 or channel 1 according to `sel`.
- Each output channel is a one-entry register slot with valid/ready handshake. A stalled output does not corrupt the other channel.
- Used wherever one stream is steered to one of two consumers. With DATA_W=1 and both readies tied high it reduces to the classic 1x2 demux: y0 = ~sel & I, y1 = sel & I, delayed by one clock.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_out_slot.sv | 74 +++++++
 rtl/demux_1to2.sv | 99 +++++++++
 tb/tb_demux_1to2.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants for the registered 1-to-2 demultiplexer.
//   SEL_CH0 : value of sel that steers the input word to output channel 0
//   SEL_CH1 : value of sel that steers the input word to output channel 1
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam logic SEL_CH0 = 1'b0;
  localparam logic SEL_CH1 = 1'b1;

endpackage : demux_pkg

// File: rtl/demux_out_slot.sv
// -----------------------------------------------------------------------------
// demux_out_slot
// One-entry output register slot with a valid/ready handshake.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   load      in   capture din this cycle (only asserted while free is 1)
//   din       in   word to capture
//   pop_ready in   downstream consumer accepts the held word
//   dout      out  held word (registered)
//   valid     out  slot holds a word (registered)
//   free      out  slot can take a word this cycle (empty, or popping now)
// -----------------------------------------------------------------------------
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DATA_W       = 1,
  parameter int CLEAR_ON_POP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              free
);

  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic [DATA_W-1:0] data_nxt_s;
  logic              valid_nxt_s;
  logic              pop_s;

  assign pop_s = valid_r & pop_ready;
  // A slot that is popping this cycle can be refilled in the same cycle,
  // which gives one word per clock of throughput.
  assign free  = ~valid_r | pop_ready;
  assign dout  = data_r;
  assign valid = valid_r;

  // Next-state selection: a load wins over a pop, so pop+load keeps valid high.
  always_comb begin
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    if (load) begin
      data_nxt_s  = din;
      valid_nxt_s = 1'b1;
    end else if (pop_s) begin
      valid_nxt_s = 1'b0;
      if (CLEAR_ON_POP != 0) begin
        data_nxt_s = '0;
      end else begin
        data_nxt_s = data_r;
      end
    end else begin
      data_nxt_s  = data_r;
      valid_nxt_s = valid_r;
    end
  end

  // Slot storage; reset discards any held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

endmodule : demux_out_slot

// File: rtl/demux_1to2.sv
// -----------------------------------------------------------------------------
// demux_1to2
// Registered 1-to-2 demultiplexer. The input word is steered by sel into one
// of two independent one-entry output slots, each with its own valid/ready
// handshake, so a stalled consumer never blocks or corrupts the other channel.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   I        in   input data word
//   sel      in   destination: SEL_CH0 -> channel 0, SEL_CH1 -> channel 1
//   i_valid  in   input word present
//   i_ready  out  selected slot can take the word (combinational)
//   y0       out  channel 0 data (registered)
//   y0_valid out  channel 0 holds a word
//   y0_ready in   channel 0 consumer accepts
//   y1       out  channel 1 data (registered)
//   y1_valid out  channel 1 holds a word
//   y1_ready in   channel 1 consumer accepts
// -----------------------------------------------------------------------------
module demux_1to2
  import demux_pkg::*;
#(
  parameter int DATA_W       = 1,
  parameter int CLEAR_ON_POP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] I,
  input  logic              sel,
  input  logic              i_valid,
  output logic              i_ready,
  output logic [DATA_W-1:0] y0,
  output logic              y0_valid,
  input  logic              y0_ready,
  output logic [DATA_W-1:0] y1,
  output logic              y1_valid,
  input  logic              y1_ready
);

  logic free0_s;
  logic free1_s;
  logic load0_s;
  logic load1_s;
  logic ready_s;

  // Select decode and ready mux. i_ready is derived from sel and the selected
  // slot only, never from i_valid, so upstream may wait on it safely.
  always_comb begin
    ready_s = 1'b0;
    load0_s = 1'b0;
    load1_s = 1'b0;
    case (sel)
      SEL_CH0: begin
        ready_s = free0_s;
        load0_s = i_valid & free0_s;
      end
      SEL_CH1: begin
        ready_s = free1_s;
        load1_s = i_valid & free1_s;
      end
      default: begin
        ready_s = 1'b0;
        load0_s = 1'b0;
        load1_s = 1'b0;
      end
    endcase
  end

  assign i_ready = ready_s;

  demux_out_slot #(
    .DATA_W      (DATA_W),
    .CLEAR_ON_POP(CLEAR_ON_POP)
  ) u_slot0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load0_s),
    .din      (I),
    .pop_ready(y0_ready),
    .dout     (y0),
    .valid    (y0_valid),
    .free     (free0_s)
  );

  demux_out_slot #(
    .DATA_W      (DATA_W),
    .CLEAR_ON_POP(CLEAR_ON_POP)
  ) u_slot1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load1_s),
    .din      (I),
    .pop_ready(y1_ready),
    .dout     (y1),
    .valid    (y1_valid),
    .free     (free1_s)
  );

endmodule : demux_1to2

// File: tb/tb_demux_1to2.sv
// -----------------------------------------------------------------------------
// tb_demux_1to2
// Directed bench for demux_1to2. Main instance: DATA_W=8, CLEAR_ON_POP=1.
// A second instance (DATA_W=1, CLEAR_ON_POP=0) shares the controls and checks
// that popped data holds its last value in that configuration.
// -----------------------------------------------------------------------------
module tb_demux_1to2;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       sel;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] y0;
  logic       y0_valid;
  logic       y0_ready;
  logic [7:0] y1;
  logic       y1_valid;
  logic       y1_ready;

  logic [0:0] h_i;
  logic       h_i_ready;
  logic [0:0] h_y0;
  logic       h_y0_valid;
  logic [0:0] h_y1;
  logic       h_y1_valid;

  int errors = 0;
  int checks = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  assign h_i = din[0:0];

  demux_1to2 #(.DATA_W(8), .CLEAR_ON_POP(1)) dut (
    .clk(clk), .rst_n(rst_n), .I(din), .sel(sel), .i_valid(i_valid),
    .i_ready(i_ready), .y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
    .y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready)
  );

  demux_1to2 #(.DATA_W(1), .CLEAR_ON_POP(0)) dut_hold (
    .clk(clk), .rst_n(rst_n), .I(h_i), .sel(sel), .i_valid(i_valid),
    .i_ready(h_i_ready), .y0(h_y0), .y0_valid(h_y0_valid), .y0_ready(y0_ready),
    .y1(h_y1), .y1_valid(h_y1_valid), .y1_ready(y1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic s, input logic v);
    din     = d;
    sel     = s;
    i_valid = v;
  endtask

  initial begin
    logic       r0, r1, exp_rdy, acc;
    logic [7:0] e0, e1;

    rst_n = 1'b0; din = 8'h00; sel = 1'b0; i_valid = 1'b0;
    y0_ready = 1'b0; y1_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_y0", y0, 8'h00);
    chk("rst_y0_valid", {7'd0, y0_valid}, 8'h00);
    chk("rst_y1", y1, 8'h00);
    chk("rst_y1_valid", {7'd0, y1_valid}, 8'h00);

    // Fill both slots, then reset asynchronously mid-cycle.
    drive(8'h12, 1'b0, 1'b1); tick();
    drive(8'h34, 1'b1, 1'b1); tick();
    drive(8'h00, 1'b0, 1'b0);
    chk("fill_y0", y0, 8'h12);
    chk("fill_y1", y1, 8'h34);
    #2 rst_n = 1'b0;
    #1;
    chk("async_y0", y0, 8'h00);
    chk("async_y0_valid", {7'd0, y0_valid}, 8'h00);
    chk("async_y1", y1, 8'h00);
    chk("async_y1_valid", {7'd0, y1_valid}, 8'h00);
    chk("async_hold_y0_valid", {7'd0, h_y0_valid}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_y0_valid", {7'd0, y0_valid}, 8'h00);
    chk("post_rst_y1_valid", {7'd0, y1_valid}, 8'h00);

    // Basic routing with both readies high.
    y0_ready = 1'b1; y1_ready = 1'b1;
    drive(8'h01, 1'b0, 1'b1); tick();
    chk("route0_y0", y0, 8'h01);
    chk("route0_y0_valid", {7'd0, y0_valid}, 8'h01);
    chk("route0_y1", y1, 8'h00);
    chk("route0_y1_valid", {7'd0, y1_valid}, 8'h00);
    drive(8'h01, 1'b1, 1'b1); tick();
    chk("route1_y1", y1, 8'h01);
    chk("route1_y0", y0, 8'h00);
    chk("route1_y0_valid", {7'd0, y0_valid}, 8'h00);
    chk("hold_y0_data", {7'd0, h_y0}, 8'h01);
    chk("hold_y0_valid", {7'd0, h_y0_valid}, 8'h00);
    drive(8'h00, 1'b1, 1'b1); tick();
    chk("route2_y1", y1, 8'h00);
    chk("route2_y1_valid", {7'd0, y1_valid}, 8'h01);
    drive(8'h00, 1'b0, 1'b0); tick();
    chk("route_idle_y1_valid", {7'd0, y1_valid}, 8'h00);

    // Streaming back-to-back.
    drive(8'hA5, 1'b0, 1'b1); #1;
    chk("stream_rdy_a", {7'd0, i_ready}, 8'h01);
    tick();
    chk("stream_y0_a5", y0, 8'hA5);
    chk("stream_y1_valid_a", {7'd0, y1_valid}, 8'h00);
    drive(8'h3C, 1'b1, 1'b1); #1;
    chk("stream_rdy_b", {7'd0, i_ready}, 8'h01);
    tick();
    chk("stream_y1_3c", y1, 8'h3C);
    chk("stream_y0_clear", y0, 8'h00);
    chk("stream_y0_valid_b", {7'd0, y0_valid}, 8'h00);
    drive(8'hFF, 1'b0, 1'b1); #1;
    chk("stream_rdy_c", {7'd0, i_ready}, 8'h01);
    tick();
    chk("stream_y0_ff", y0, 8'hFF);
    chk("stream_y1_clear", y1, 8'h00);
    chk("stream_y1_valid_c", {7'd0, y1_valid}, 8'h00);
    drive(8'h00, 1'b0, 1'b0); tick();
    chk("stream_end_y0", y0, 8'h00);

    // Backpressure on channel 0.
    y0_ready = 1'b0;
    drive(8'h11, 1'b0, 1'b1); tick();
    chk("bp_y0", y0, 8'h11);
    chk("bp_y0_valid", {7'd0, y0_valid}, 8'h01);
    drive(8'h99, 1'b0, 1'b1); #1;
    chk("bp_blocked_rdy", {7'd0, i_ready}, 8'h00);
    tick();
    chk("bp_not_taken", y0, 8'h11);
    drive(8'h22, 1'b1, 1'b1); #1;
    chk("bp_ch1_rdy", {7'd0, i_ready}, 8'h01);
    tick();
    chk("bp_ch1_y1", y1, 8'h22);
    chk("bp_ch0_still", y0, 8'h11);
    chk("bp_ch0_valid_still", {7'd0, y0_valid}, 8'h01);
    drive(8'h99, 1'b0, 1'b1);
    y0_ready = 1'b1; #1;
    chk("bp_release_rdy", {7'd0, i_ready}, 8'h01);
    tick();
    chk("bp_pending_loaded", y0, 8'h99);
    chk("bp_pending_valid", {7'd0, y0_valid}, 8'h01);
    chk("bp_y1_popped", {7'd0, y1_valid}, 8'h00);
    drive(8'h00, 1'b0, 1'b0); tick();
    chk("bp_drained", {7'd0, y0_valid}, 8'h00);

    // Pop and load on the same slot in one cycle.
    y0_ready = 1'b0;
    drive(8'h55, 1'b0, 1'b1); tick();
    chk("pl_y0_55", y0, 8'h55);
    y0_ready = 1'b1;
    drive(8'h66, 1'b0, 1'b1); tick();
    chk("pl_y0_66", y0, 8'h66);
    chk("pl_valid_kept", {7'd0, y0_valid}, 8'h01);
    drive(8'h00, 1'b0, 1'b0); tick();
    chk("pl_drained", {7'd0, y0_valid}, 8'h00);

    // Random regression against per-channel scoreboard queues.
    for (int c = 0; c < 1000; c++) begin
      din      = 8'($urandom_range(0, 255));
      sel      = 1'($urandom_range(0, 1));
      i_valid  = 1'($urandom_range(0, 1));
      y0_ready = ($urandom_range(0, 3) != 0);
      y1_ready = ($urandom_range(0, 3) != 0);
      #1;
      r0 = (q0.size() != 0) && y0_ready;
      r1 = (q1.size() != 0) && y1_ready;
      exp_rdy = sel ? ((q1.size() == 0) || y1_ready) : ((q0.size() == 0) || y0_ready);
      e0 = (q0.size() != 0) ? q0[0] : 8'h00;
      e1 = (q1.size() != 0) ? q1[0] : 8'h00;
      chk("rnd_i_ready", {7'd0, i_ready}, {7'd0, exp_rdy});
      chk("rnd_y0_valid", {7'd0, y0_valid}, {7'd0, (q0.size() != 0)});
      chk("rnd_y1_valid", {7'd0, y1_valid}, {7'd0, (q1.size() != 0)});
      chk("rnd_y0", y0, e0);
      chk("rnd_y1", y1, e1);
      if (r0) void'(q0.pop_front());
      if (r1) void'(q1.pop_front());
      acc = i_valid && exp_rdy;
      if (acc && !sel) q0.push_back(din);
      if (acc && sel) q1.push_back(din);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_demux_1to2
